// File: rtl/sisc_mem_arb.sv
// Shares one synchronous memory between the SISC fetch port (F) and the load/store port (D).
// Define ARB_RR_EN for round-robin arbitration on conflicts; otherwise D has fixed priority.
module sisc_mem_arb #(
   parameter int AW     = 16,
   parameter int DW     = 32,
   parameter int RD_LAT = 1
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          f_req,
   input  logic [AW-1:0] f_addr,
   output logic          f_gnt,
   output logic          f_rvalid,
   output logic [DW-1:0] f_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic          port_q, port_d;       // 1 = D owns the transaction, 0 = F
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    cnt_q, cnt_d;
   logic [DW-1:0] f_rdata_q, f_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          pick_d;

`ifdef ARB_RR_EN
   logic last_q, last_d;
   // On conflict the port that did not win the previous issue goes first.
   assign pick_d = d_req & (~f_req | ~last_q);
   assign last_d = (state_q == S_ISSUE) ? port_q : last_q;
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (rst_f) begin
         state_q   <= S_IDLE;
         port_q    <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         f_rdata_q <= '0;
         d_rdata_q <= '0;
`ifdef ARB_RR_EN
         last_q    <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         port_q    <= port_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         f_rdata_q <= f_rdata_d;
         d_rdata_q <= d_rdata_d;
`ifdef ARB_RR_EN
         last_q    <= last_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      port_d    = port_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      f_rdata_d = f_rdata_q;
      d_rdata_d = d_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (f_req | d_req) begin
               state_d = S_ISSUE;
               port_d  = pick_d;
               we_d    = pick_d & d_we;
               addr_d  = pick_d ? d_addr : f_addr;
               wdata_d = d_wdata;
            end
         end
         S_ISSUE: begin
            if (we_q) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
               cnt_d   = 2'(RD_LAT - 1);
            end
         end
         S_WAIT: begin
            // Last wait cycle: memory data is valid now, capture for the owner only.
            if (cnt_q == 2'd0) begin
               state_d = S_RESP;
               if (port_q) d_rdata_d = mem_rdata;
               else        f_rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_en    = (state_q == S_ISSUE);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = mem_en ? addr_q : '0;
   assign mem_wdata = mem_we ? wdata_q : '0;
   assign f_gnt     = mem_en & ~port_q;
   assign d_gnt     = mem_en & port_q;
   assign f_rvalid  = (state_q == S_RESP) & ~port_q;
   assign d_rvalid  = (state_q == S_RESP) & port_q;
   assign f_rdata   = f_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_sisc_mem_arb.sv
// Bench for sisc_mem_arb: two instances (RD_LAT 1 and 3), each with a latency-matched RAM,
// checked every cycle against a transaction-level timing/data model.
module tb_sisc_mem_arb;
   localparam int AW = 16;
   localparam int DW = 32;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_f     [2];
   logic          f_req     [2];
   logic [AW-1:0] f_addr    [2];
   logic          f_gnt     [2];
   logic          f_rvalid  [2];
   logic [DW-1:0] f_rdata   [2];
   logic          d_req     [2];
   logic          d_we      [2];
   logic [AW-1:0] d_addr    [2];
   logic [DW-1:0] d_wdata   [2];
   logic          d_gnt     [2];
   logic          d_rvalid  [2];
   logic [DW-1:0] d_rdata   [2];
   logic          mem_en    [2];
   logic          mem_we    [2];
   logic [AW-1:0] mem_addr  [2];
   logic [DW-1:0] mem_wdata [2];
   logic [DW-1:0] mem_rdata [2];
   logic          busy      [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_inst
         localparam int LAT = (gi == 0) ? 1 : 3;
         logic [DW-1:0] ram  [256];
         logic [DW-1:0] pipe [4];

         sisc_mem_arb #(.AW(AW), .DW(DW), .RD_LAT(LAT)) u_dut (
            .clk(clk), .rst_f(rst_f[gi]),
            .f_req(f_req[gi]), .f_addr(f_addr[gi]), .f_gnt(f_gnt[gi]),
            .f_rvalid(f_rvalid[gi]), .f_rdata(f_rdata[gi]),
            .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
            .d_gnt(d_gnt[gi]), .d_rvalid(d_rvalid[gi]), .d_rdata(d_rdata[gi]),
            .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
            .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]), .busy(busy[gi])
         );

         // Synchronous RAM whose read data appears LAT cycles after the access cycle.
         always @(posedge clk) begin
            if (mem_en[gi] && mem_we[gi]) ram[mem_addr[gi][7:0]] <= mem_wdata[gi];
            pipe[0] <= ram[mem_addr[gi][7:0]];
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
         end
         assign mem_rdata[gi] = pipe[LAT-1];
      end
   endgenerate

   int total = 0;
   int bad   = 0;
   int n     = 0;
   int sel   = 0;
   int lat   = 1;

   // Reference model state: cycle numbers at which events are due.
   int            free_c, busy_from, gnt_c, rv_c, clr_c;
   int            gnt_cyc [2];
   bit            g_d, g_we, rv_d, last_d;
   logic [AW-1:0] g_addr;
   logic [DW-1:0] g_wdata, rv_data;
   logic [DW-1:0] exp_rd [2];
   logic [DW-1:0] shadow [2][256];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", tag, sel, n, obs, exp);
      end
   endtask

   task automatic model_init();
      n = 0; free_c = 0; busy_from = 0; gnt_c = -1; rv_c = -1; clr_c = -1;
      gnt_cyc[0] = -1; gnt_cyc[1] = -1; last_d = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      lat = (sel == 0) ? 1 : 3;
   endtask

   // Consumes the inputs presented in cycle n.
   task automatic arb_model();
      bit pick;
      if (rst_f[sel]) begin
         if (gnt_c > n) gnt_c = -1;
         if (rv_c > n) rv_c = -1;
         free_c = n + 1; clr_c = n + 1; last_d = 1'b1;
      end else if (n >= free_c && (f_req[sel] || d_req[sel])) begin
`ifdef ARB_RR_EN
         pick = (f_req[sel] && d_req[sel]) ? !last_d : d_req[sel];
`else
         pick = d_req[sel];
`endif
         last_d = pick; g_d = pick; g_we = pick && d_we[sel];
         g_addr = pick ? d_addr[sel] : f_addr[sel];
         g_wdata = d_wdata[sel];
         gnt_c = n + 1; gnt_cyc[pick] = n + 1; busy_from = n + 1;
         if (g_we) begin
            shadow[sel][g_addr[7:0]] = g_wdata;
            free_c = n + 2;
         end else begin
            rv_c = n + 2 + lat; rv_d = pick; rv_data = shadow[sel][g_addr[7:0]];
            free_c = n + 3 + lat;
         end
         $display("inst=%0d cyc=%0d grant %s %s addr=%h wdata=%h last=%0d", sel, n + 1,
                  pick ? "D" : "F", g_we ? "WR" : "RD", g_addr, g_wdata, last_d);
      end
   endtask

   task automatic cycle();
      bit e_en;
      arb_model();
      @(posedge clk);
      #1;
      n++;
      if (n == clr_c) begin exp_rd[0] = '0; exp_rd[1] = '0; end
      if (n == rv_c) exp_rd[rv_d] = rv_data;
      e_en = (gnt_c == n);
      check_eq("mem_en", mem_en[sel], e_en);
      check_eq("f_gnt", f_gnt[sel], e_en && !g_d);
      check_eq("d_gnt", d_gnt[sel], e_en && g_d);
      check_eq("mem_we", mem_we[sel], e_en && g_we);
      if (e_en) check_eq("mem_addr", mem_addr[sel], g_addr);
      if (e_en && g_we) check_eq("mem_wdata", mem_wdata[sel], g_wdata);
      check_eq("f_rvalid", f_rvalid[sel], (rv_c == n) && !rv_d);
      check_eq("d_rvalid", d_rvalid[sel], (rv_c == n) && rv_d);
      check_eq("busy", busy[sel], (n >= busy_from) && (n < free_c));
      check_eq("f_rdata", f_rdata[sel], exp_rd[0]);
      check_eq("d_rdata", d_rdata[sel], exp_rd[1]);
      // Requesters drop req the cycle after their grant.
      if (gnt_cyc[0] == n - 1) f_req[sel] = 1'b0;
      if (gnt_cyc[1] == n - 1) d_req[sel] = 1'b0;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      d_addr[sel] = a; d_wdata[sel] = d; d_we[sel] = 1'b1; d_req[sel] = 1'b1;
      cycle(); cycle();
      d_we[sel] = 1'b0;
   endtask

   task automatic reset_test();
      rst_f[sel] = 1'b1;
      cycle(); cycle();
      rst_f[sel] = 1'b0;
      check_eq("rst_f_gnt", f_gnt[sel], 0);
      check_eq("rst_d_gnt", d_gnt[sel], 0);
      check_eq("rst_rvalid", {f_rvalid[sel], d_rvalid[sel]}, 0);
      check_eq("rst_mem", {mem_en[sel], mem_we[sel], mem_addr[sel]}, 0);
      check_eq("rst_mem_wdata", mem_wdata[sel], 0);
      check_eq("rst_busy", busy[sel], 0);
      check_eq("rst_f_rdata", f_rdata[sel], 0);
      check_eq("rst_d_rdata", d_rdata[sel], 0);
   endtask

   task automatic rand_phase(input int cycles);
      for (int k = 0; k < cycles; k++) begin
         if (rst_f[sel]) rst_f[sel] = 1'b0;
         else            rst_f[sel] = ($urandom_range(63) == 0);
         if (!f_req[sel] && $urandom_range(2) == 0) begin
            f_req[sel] = 1'b1; f_addr[sel] = AW'($urandom_range(15));
         end
         if (!d_req[sel] && $urandom_range(2) == 0) begin
            d_req[sel] = 1'b1; d_we[sel] = 1'($urandom_range(1));
            d_addr[sel] = AW'($urandom_range(15)); d_wdata[sel] = $urandom;
         end
         cycle();
      end
      rst_f[sel] = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (gnt_cyc[0] < n - 1) f_req[sel] = 1'b0;
         if (gnt_cyc[1] < n - 1) d_req[sel] = 1'b0;
         cycle();
      end
   endtask

   initial begin
      int c;
      for (int i = 0; i < 2; i++) begin
         rst_f[i] = 1'b1; f_req[i] = 1'b0; f_addr[i] = '0; d_req[i] = 1'b0;
         d_we[i] = 1'b0; d_addr[i] = '0; d_wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst_f[0] = 1'b0; rst_f[1] = 1'b0;

      // ---------------- instance 0, RD_LAT = 1 ----------------
      sel = 0; model_init();
      reset_test();

      d_we[sel] = 1'b1; d_addr[sel] = 16'h0010; d_wdata[sel] = 32'hDEADBEEF; d_req[sel] = 1'b1;
      cycle();
      check_eq("t3_mem_en_we", {mem_en[sel], mem_we[sel], d_gnt[sel]}, 3'b111);
      check_eq("t3_addr", mem_addr[sel], 16'h0010);
      check_eq("t3_wdata", mem_wdata[sel], 32'hDEADBEEF);
      cycle();
      d_we[sel] = 1'b0;
      check_eq("t3_busy", busy[sel], 0);
      check_eq("t3_no_rvalid", d_rvalid[sel], 0);

      wr(16'h0004, 32'h88000001);
      f_addr[sel] = 16'h0004; f_req[sel] = 1'b1;
      cycle();
      check_eq("t2_f_gnt", {f_gnt[sel], mem_en[sel], mem_we[sel]}, 3'b110);
      check_eq("t2_addr", mem_addr[sel], 16'h0004);
      cycle(); cycle();
      check_eq("t2_f_rvalid", f_rvalid[sel], 1);
      check_eq("t2_f_rdata", f_rdata[sel], 32'h88000001);
      cycle();
      check_eq("t2_busy", busy[sel], 0);

      for (int a = 0; a < 16; a++) wr(AW'(a), $urandom);

      for (int r = 0; r < 2; r++) begin
         f_addr[sel] = 16'h0001; d_addr[sel] = 16'h0002; d_we[sel] = 1'b0;
         f_req[sel] = 1'b1; d_req[sel] = 1'b1;
         cycle();
`ifdef ARB_RR_EN
         check_eq("t4_first_f", f_gnt[sel], 1);
`else
         check_eq("t4_first_d", d_gnt[sel], 1);
`endif
         repeat (4) cycle();
`ifdef ARB_RR_EN
         check_eq("t4_second_d", d_gnt[sel], 1);
`else
         check_eq("t4_second_f", f_gnt[sel], 1);
`endif
         repeat (3) cycle();
      end

      d_addr[sel] = 16'h0005; d_we[sel] = 1'b0; d_req[sel] = 1'b1;
      cycle(); cycle();
      rst_f[sel] = 1'b1;
      cycle();
      rst_f[sel] = 1'b0;
      check_eq("t5_rvalid", {f_rvalid[sel], d_rvalid[sel]}, 0);
      check_eq("t5_busy", busy[sel], 0);
      check_eq("t5_rdata", {f_rdata[sel], d_rdata[sel]}, 0);
      cycle();

      rand_phase(1500);

      // ---------------- instance 1, RD_LAT = 3 ----------------
      sel = 1; model_init();
      reset_test();
      wr(16'h0020, 32'h12345678);
      f_addr[sel] = 16'h0020; f_req[sel] = 1'b1;
      c = n;
      cycle();
      check_eq("t6_f_gnt", f_gnt[sel], 1);
      repeat (3) cycle();
      check_eq("t6_early", f_rvalid[sel], 0);
      cycle();
      check_eq("t6_cycle", n - c, 5);
      check_eq("t6_f_rvalid", f_rvalid[sel], 1);
      check_eq("t6_f_rdata", f_rdata[sel], 32'h12345678);
      cycle();
      for (int a = 0; a < 16; a++) wr(AW'(a), $urandom);
      rand_phase(1500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
